// File: rtl/register_scoreboard_pkg.sv
// Shared sizing and types for the register scoreboard: architectural register file
// geometry and the default per-register write-in-flight depth.
package register_scoreboard_pkg;

  localparam int NUM_REGISTERS           = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
  localparam int MAX_INFLIGHT_DEFAULT    = 3;
  localparam int TOTAL_W                 = 7;

  typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;

  function automatic int cnt_width(input int max_inflight);
    return (max_inflight < 2) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/register_scoreboard_counter.sv
// One saturating up/down counter tracking outstanding writes to a single register.
// Overflow/underflow are single-cycle pulses; the counter holds when either occurs.
module scoreboard_counter #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             saturated,
  output logic             zero,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign saturated  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign zero       = (count_q == '0);
  assign count      = count_q;
  assign count_next = count_d;

  // Simultaneous inc and dec cancel, so neither error can fire in that case.
  always_comb begin
    count_d   = count_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (saturated) overflow = 1'b1;
      else           count_d  = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (zero) underflow = 1'b1;
      else      count_d   = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/register_scoreboard.sv
// Read-after-write interlock: per-register outstanding-write counters feeding the
// decode-stage contention inputs, with flush, bypass-aware retire and sticky errors.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] read_1_index,
  output logic                               read_1_contended,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] read_2_index,
  output logic                               read_2_contended,
  input  logic                               issue_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_rd,
  input  logic                               issue_rd_valid,
  output logic                               issue_ready,
  input  logic                               wb_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] wb_rd,
  input  logic                               flush,
  output logic [TOTAL_W-1:0]                 inflight_total,
  output logic                               error_underflow,
  output logic                               error_overflow
);

  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  logic issue_fire;
  logic wb_fire;

  logic [NUM_REGISTERS-1:0][CNT_W-1:0] count;
  logic [NUM_REGISTERS-1:0][CNT_W-1:0] count_next;
  logic [NUM_REGISTERS-1:0]            sat;
  logic [NUM_REGISTERS-1:0]            zero;
  logic [NUM_REGISTERS-1:0]            ovf;
  logic [NUM_REGISTERS-1:0]            udf;

  logic [TOTAL_W-1:0] total_q, total_d;
  logic               error_underflow_q, error_underflow_d;
  logic               error_overflow_q, error_overflow_d;
  logic               rd1_bypass, rd2_bypass, issue_retire_hit;

  assign issue_fire = issue_valid && issue_rd_valid && (issue_rd != '0) && !flush;
  assign wb_fire    = wb_valid && (wb_rd != '0) && !flush;

  // x0 is hard-wired: never busy, never saturated, never errors.
  assign count[0]      = '0;
  assign count_next[0] = '0;
  assign sat[0]        = 1'b0;
  assign zero[0]       = 1'b1;
  assign ovf[0]        = 1'b0;
  assign udf[0]        = 1'b0;

  for (genvar r = 1; r < NUM_REGISTERS; r++) begin : g_cnt
    scoreboard_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (issue_fire && (issue_rd == reg_index_t'(r))),
      .dec        (wb_fire && (wb_rd == reg_index_t'(r))),
      .clear      (flush),
      .count      (count[r]),
      .count_next (count_next[r]),
      .saturated  (sat[r]),
      .zero       (zero[r]),
      .overflow   (ovf[r]),
      .underflow  (udf[r])
    );
  end

  // A retiring last write is already visible in the write-through regfile.
  always_comb begin
    rd1_bypass       = WB_BYPASS && wb_fire && (wb_rd == read_1_index) &&
                       (count[read_1_index] == CNT_W'(1));
    rd2_bypass       = WB_BYPASS && wb_fire && (wb_rd == read_2_index) &&
                       (count[read_2_index] == CNT_W'(1));
    read_1_contended = (read_1_index != '0) && !zero[read_1_index] && !rd1_bypass;
    read_2_contended = (read_2_index != '0) && !zero[read_2_index] && !rd2_bypass;
    issue_retire_hit = wb_fire && (wb_rd == issue_rd);
    issue_ready      = !(issue_rd_valid && (issue_rd != '0) && sat[issue_rd] &&
                         !issue_retire_hit);
  end

  always_comb begin
    total_d = '0;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      total_d = total_d + TOTAL_W'(count_next[r]);
    end
    error_underflow_d = error_underflow_q | (|udf);
    error_overflow_d  = error_overflow_q  | (|ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q           <= '0;
      error_underflow_q <= 1'b0;
      error_overflow_q  <= 1'b0;
    end else begin
      total_q           <= total_d;
      error_underflow_q <= error_underflow_d;
      error_overflow_q  <= error_overflow_d;
    end
  end

  assign inflight_total  = total_q;
  assign error_underflow = error_underflow_q;
  assign error_overflow  = error_overflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: issue/retire, saturation, flush, x0,
// underflow, same-cycle issue+retire and mid-operation reset.
module tb_register_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] read_1_index, read_2_index;
  logic       read_1_contended, read_2_contended;
  logic       issue_valid, issue_rd_valid, issue_ready;
  logic [4:0] issue_rd;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic [6:0] inflight_total;
  logic       error_underflow, error_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .read_1_index     (read_1_index),
    .read_1_contended (read_1_contended),
    .read_2_index     (read_2_index),
    .read_2_contended (read_2_contended),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_rd_valid   (issue_rd_valid),
    .issue_ready      (issue_ready),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .flush            (flush),
    .inflight_total   (inflight_total),
    .error_underflow  (error_underflow),
    .error_overflow   (error_overflow)
  );

  task automatic idle();
    issue_valid = 1'b0; issue_rd_valid = 1'b0; issue_rd = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd_valid = 1'b1; issue_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); read_1_index = 5'd5; read_2_index = 5'd7;
    cycle(); cycle();
    rst = 1'b0; #1;
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL reset_rd1: got %0b want 0", read_1_contended); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", issue_ready); end
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", inflight_total); end
    checks++; if ({error_underflow, error_overflow} !== 2'b00) begin errors++; $display("FAIL reset_errors: got %b want 00", {error_underflow, error_overflow}); end
  endtask

  task automatic test_issue_bypass();
    issue(5'd5); read_1_index = 5'd5; read_2_index = 5'd5; #1;
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL t1_same_cycle_issue: got %0b want 0", read_1_contended); end
    cycle(); idle(); #1;
    checks++; if (read_1_contended !== 1'b1) begin errors++; $display("FAIL t1_contended: got %0b want 1", read_1_contended); end
    checks++; if (inflight_total !== 7'd1) begin errors++; $display("FAIL t1_total: got %0d want 1", inflight_total); end
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL t1_bypass_rd1: got %0b want 0", read_1_contended); end
    checks++; if (read_2_contended !== 1'b0) begin errors++; $display("FAIL t1_bypass_rd2: got %0b want 0", read_2_contended); end
    cycle(); idle(); #1;
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t1_total_after_wb: got %0d want 0", inflight_total); end
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL t1_rd1_after_wb: got %0b want 0", read_1_contended); end
  endtask

  task automatic test_saturation();
    read_1_index = 5'd7;
    issue(5'd7);
    cycle(); cycle(); cycle();
    issue_valid = 1'b0; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_sat: got %0b want 0", issue_ready); end
    checks++; if (inflight_total !== 7'd3) begin errors++; $display("FAIL t2_total_sat: got %0d want 3", inflight_total); end
    issue_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_retire: got %0b want 1", issue_ready); end
    cycle(); wb_valid = 1'b0; issue_valid = 1'b0; #1;
    checks++; if (inflight_total !== 7'd3) begin errors++; $display("FAIL t2_total_swap: got %0d want 3", inflight_total); end
    checks++; if (error_overflow !== 1'b0) begin errors++; $display("FAIL t2_no_ovf: got %0b want 0", error_overflow); end
    issue_valid = 1'b1;
    cycle(); idle(); #1;
    checks++; if (error_overflow !== 1'b1) begin errors++; $display("FAIL t2_ovf: got %0b want 1", error_overflow); end
    checks++; if (inflight_total !== 7'd3) begin errors++; $display("FAIL t2_total_held: got %0d want 3", inflight_total); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    cycle(); cycle(); cycle(); idle(); #1;
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t2_drain: got %0d want 0", inflight_total); end
    checks++; if (error_underflow !== 1'b0) begin errors++; $display("FAIL t2_no_udf: got %0b want 0", error_underflow); end
  endtask

  task automatic test_flush();
    issue(5'd3); cycle();
    issue(5'd4); cycle();
    issue(5'd9); cycle();
    idle(); read_1_index = 5'd3; read_2_index = 5'd9; #1;
    checks++; if (inflight_total !== 7'd3) begin errors++; $display("FAIL t3_total_pre: got %0d want 3", inflight_total); end
    checks++; if ({read_1_contended, read_2_contended} !== 2'b11) begin errors++; $display("FAIL t3_pre_contended: got %b want 11", {read_1_contended, read_2_contended}); end
    issue(5'd10); flush = 1'b1;
    cycle(); idle(); #1;
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t3_total_flush: got %0d want 0", inflight_total); end
    checks++; if ({read_1_contended, read_2_contended} !== 2'b00) begin errors++; $display("FAIL t3_flushed: got %b want 00", {read_1_contended, read_2_contended}); end
    read_1_index = 5'd10; read_2_index = 5'd4; #1;
    checks++; if ({read_1_contended, read_2_contended} !== 2'b00) begin errors++; $display("FAIL t3_x10_x4: got %b want 00", {read_1_contended, read_2_contended}); end
    checks++; if (error_overflow !== 1'b1) begin errors++; $display("FAIL t3_ovf_sticky: got %0b want 1", error_overflow); end
  endtask

  task automatic test_x0_underflow();
    issue(5'd0); read_1_index = 5'd0; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_x0: got %0b want 1", issue_ready); end
    cycle(); idle(); #1;
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL t4_x0_contended: got %0b want 0", read_1_contended); end
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t4_x0_total: got %0d want 0", inflight_total); end
    wb_valid = 1'b1; wb_rd = 5'd12;
    cycle(); idle(); #1;
    checks++; if (error_underflow !== 1'b1) begin errors++; $display("FAIL t4_udf: got %0b want 1", error_underflow); end
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t4_udf_total: got %0d want 0", inflight_total); end
    cycle(); cycle();
    checks++; if (error_underflow !== 1'b1) begin errors++; $display("FAIL t4_udf_sticky: got %0b want 1", error_underflow); end
  endtask

  task automatic test_same_cycle();
    issue(5'd2); read_1_index = 5'd2;
    cycle(); idle(); #1;
    checks++; if (read_1_contended !== 1'b1) begin errors++; $display("FAIL t5_pre: got %0b want 1", read_1_contended); end
    issue(5'd2); wb_valid = 1'b1; wb_rd = 5'd2; #1;
    checks++; if (read_1_contended !== 1'b0) begin errors++; $display("FAIL t5_bypass: got %0b want 0", read_1_contended); end
    cycle(); idle(); #1;
    checks++; if (read_1_contended !== 1'b1) begin errors++; $display("FAIL t5_next: got %0b want 1", read_1_contended); end
    checks++; if (inflight_total !== 7'd1) begin errors++; $display("FAIL t5_total: got %0d want 1", inflight_total); end
  endtask

  task automatic test_reset_mid();
    issue(5'd20); cycle();
    issue(5'd21); rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd2;
    cycle(); rst = 1'b0; idle(); read_1_index = 5'd2; read_2_index = 5'd20; #1;
    checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL t6_total: got %0d want 0", inflight_total); end
    checks++; if ({read_1_contended, read_2_contended} !== 2'b00) begin errors++; $display("FAIL t6_contended: got %b want 00", {read_1_contended, read_2_contended}); end
    checks++; if ({error_underflow, error_overflow} !== 2'b00) begin errors++; $display("FAIL t6_errors: got %b want 00", {error_underflow, error_overflow}); end
    read_1_index = 5'd21; issue_rd_valid = 1'b1; issue_rd = 5'd21; #1;
    checks++; if ({read_1_contended, issue_ready} !== 2'b01) begin errors++; $display("FAIL t6_x21: got %b want 01", {read_1_contended, issue_ready}); end
    idle(); cycle();
  endtask

  initial begin
    test_reset();
    test_issue_bypass();
    test_saturation();
    test_flush();
    test_x0_underflow();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
